// File: rtl/sdram_frame_reader.sv
// rtl/sdram_frame_reader.sv - burst-reads one stored frame from SDRAM and streams its pixels
//
// Purpose: issues sequential BurstLengthSDRAM-word read requests starting at
// BaseAddr, captures each burst into one of two ping-pong buffers and drains
// the buffers as a valid/ready pixel stream with line/frame end markers.
//
// Ports:
//   CLK, RST                  clock, asynchronous active-low reset
//   i_start                   one-cycle pulse, starts a frame read when idle
//   o_busy, o_done            frame in progress / one-cycle completion pulse
//   o_sdram_enable/rw/addr    one-cycle read request to the SDRAM controller
//   i_sdram_busy              controller cannot accept a request
//   i_sdram_valid_rd/data     read word strobe and data from the controller
//   o_pixel, o_valid, i_ready pixel stream handshake
//   o_line_end, o_frame_end   markers qualifying o_pixel
//   o_overrun                 sticky flag for read words arriving outside a burst
module sdram_frame_reader #(
  parameter int FrameWidth        = 640,
  parameter int FrameHeight       = 480,
  parameter int PixelBitWidth     = 16,
  parameter int AddressWidthSDRAM = 24,
  parameter int BurstLengthSDRAM  = 8,
  parameter int BaseAddr          = 0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         i_start,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_sdram_enable,
  output logic                         o_sdram_rw,
  output logic [AddressWidthSDRAM-1:0] o_sdram_addr,
  input  logic                         i_sdram_busy,
  input  logic                         i_sdram_valid_rd,
  input  logic [PixelBitWidth-1:0]     i_sdram_data,
  output logic [PixelBitWidth-1:0]     o_pixel,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_line_end,
  output logic                         o_frame_end,
  output logic                         o_overrun
);

  localparam int AW          = AddressWidthSDRAM;
  localparam int TotalPixels = FrameWidth * FrameHeight;
  localparam int NumBursts   = TotalPixels / BurstLengthSDRAM;
  localparam int BurstW      = (NumBursts > 1) ? $clog2(NumBursts) : 1;
  localparam int WordW       = (BurstLengthSDRAM > 1) ? $clog2(BurstLengthSDRAM) : 1;
  localparam int ColW        = (FrameWidth > 1) ? $clog2(FrameWidth) : 1;
  localparam int RowW        = (FrameHeight > 1) ? $clog2(FrameHeight) : 1;

  localparam logic [BurstW-1:0] LastBurst = BurstW'(NumBursts - 1);
  localparam logic [WordW-1:0]  LastWord  = WordW'(BurstLengthSDRAM - 1);
  localparam logic [ColW-1:0]   LastCol   = ColW'(FrameWidth - 1);
  localparam logic [RowW-1:0]   LastRow   = RowW'(FrameHeight - 1);
  localparam logic [AW-1:0]     BaseAddrW = AW'(BaseAddr);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COLLECT,
    FINISH
  } state_e;

  state_e              state_q;
  logic                busy_q;
  logic                done_q;
  logic                overrun_q;
  logic [BurstW-1:0]   burst_q;
  logic [WordW-1:0]    word_q;
  logic                fill_sel_q;
  logic                drain_sel_q;
  logic [1:0]          full_q;
  logic [WordW-1:0]    rd_idx_q;
  logic [ColW-1:0]     col_q;
  logic [RowW-1:0]     row_q;

  logic [PixelBitWidth-1:0] pix_mem [2][BurstLengthSDRAM];

  logic          req_fire;
  logic          capture;
  logic          drain_full;
  logic          handshake;
  logic          last_pixel;
  logic [AW-1:0] req_addr;

  // The request is combinational on the controller's busy so that it goes out
  // in the very cycle the controller frees up; the address wraps naturally.
  assign req_fire   = (state_q == ISSUE) && !i_sdram_busy && !full_q[fill_sel_q];
  assign capture    = (state_q == COLLECT) && i_sdram_valid_rd;
  assign drain_full = full_q[drain_sel_q];
  assign handshake  = drain_full && i_ready;
  assign last_pixel = (col_q == LastCol) && (row_q == LastRow);
  assign req_addr   = BaseAddrW + AW'(burst_q) * AW'(BurstLengthSDRAM);

  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_overrun      = overrun_q;
  assign o_sdram_enable = req_fire;
  assign o_sdram_rw     = req_fire;
  assign o_sdram_addr   = req_fire ? req_addr : '0;
  assign o_valid        = drain_full;
  assign o_pixel        = drain_full ? pix_mem[drain_sel_q][rd_idx_q] : '0;
  assign o_line_end     = drain_full && (col_q == LastCol);
  assign o_frame_end    = drain_full && last_pixel;

  always_ff @(posedge CLK) begin
    if (capture) begin
      pix_mem[fill_sel_q][word_q] <= i_sdram_data;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      burst_q     <= '0;
      word_q      <= '0;
      fill_sel_q  <= 1'b0;
      drain_sel_q <= 1'b0;
      full_q      <= '0;
      rd_idx_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
    end else begin
      done_q <= 1'b0;

      if (i_sdram_valid_rd && (state_q != COLLECT)) begin
        overrun_q <= 1'b1;
      end

      // Drain side runs independently of the request FSM; the fill side only
      // ever touches the other buffer, so both full-flag updates can land together.
      if (handshake) begin
        if (rd_idx_q == LastWord) begin
          rd_idx_q            <= '0;
          full_q[drain_sel_q] <= 1'b0;
          drain_sel_q         <= !drain_sel_q;
        end else begin
          rd_idx_q <= rd_idx_q + WordW'(1);
        end
        if (col_q == LastCol) begin
          col_q <= '0;
          row_q <= (row_q == LastRow) ? '0 : row_q + RowW'(1);
        end else begin
          col_q <= col_q + ColW'(1);
        end
      end

      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q     <= ISSUE;
            busy_q      <= 1'b1;
            overrun_q   <= 1'b0;
            burst_q     <= '0;
            word_q      <= '0;
            fill_sel_q  <= 1'b0;
            drain_sel_q <= 1'b0;
            full_q      <= '0;
            rd_idx_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
          end
        end
        ISSUE: begin
          if (req_fire) begin
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          if (i_sdram_valid_rd) begin
            if (word_q == LastWord) begin
              word_q             <= '0;
              full_q[fill_sel_q] <= 1'b1;
              fill_sel_q         <= !fill_sel_q;
              burst_q            <= burst_q + BurstW'(1);
              state_q            <= (burst_q == LastBurst) ? FINISH : ISSUE;
            end else begin
              word_q <= word_q + WordW'(1);
            end
          end
        end
        FINISH: begin
          if (handshake && last_pixel) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_frame_reader.sv
// tb/tb_sdram_frame_reader.sv - self-checking bench for sdram_frame_reader
module tb_sdram_frame_reader;
  localparam int FW     = 16;
  localparam int FH     = 2;
  localparam int BL     = 8;
  localparam int AW     = 24;
  localparam int PW     = 16;
  localparam int BASE   = 'h100;
  localparam int TOTAL  = FW * FH;
  localparam int NB     = TOTAL / BL;
  localparam int WFW    = 8;
  localparam int WFH    = 2;
  localparam int WBASE  = (1 << 24) - 8;
  localparam int WTOTAL = WFW * WFH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic w_start = 1'b0;
  logic ready = 1'b0;
  logic w_ready = 1'b1;
  logic sd_busy = 1'b0;
  logic w_sd_busy = 1'b0;
  logic [1:0] sd_valid = '0;
  logic [PW-1:0] sd_data [2];

  logic en0, rw0, en1, rw1;
  logic [AW-1:0] addr0, addr1;
  logic busy, done, valid, line_end, frame_end, overrun;
  logic [PW-1:0] pixel;
  logic w_busy, w_done, w_valid, w_line_end, w_frame_end, w_overrun;
  logic [PW-1:0] w_pixel;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int ready_mode = 1;
  logic busy_rand = 1'b0;
  logic busy_force = 1'b0;
  int inject_at = -1;
  int pstart [2] = '{-100, -100};
  int paddr [2] = '{0, 0};

  int req_cnt, pix_out, done_cnt, first_req_cyc, last_pix;
  logic prev_hold, last_hs;
  logic [PW-1:0] prev_pix;
  int req_log [$];
  int wreq [$];
  logic [17:0] wpix [$];
  int w_done_cnt = 0;

  sdram_frame_reader #(
    .FrameWidth(FW), .FrameHeight(FH), .PixelBitWidth(PW),
    .AddressWidthSDRAM(AW), .BurstLengthSDRAM(BL), .BaseAddr(BASE)
  ) u_dut (
    .CLK(clk), .RST(rst_n), .i_start(start), .o_busy(busy), .o_done(done),
    .o_sdram_enable(en0), .o_sdram_rw(rw0), .o_sdram_addr(addr0),
    .i_sdram_busy(sd_busy), .i_sdram_valid_rd(sd_valid[0]), .i_sdram_data(sd_data[0]),
    .o_pixel(pixel), .o_valid(valid), .i_ready(ready),
    .o_line_end(line_end), .o_frame_end(frame_end), .o_overrun(overrun)
  );

  sdram_frame_reader #(
    .FrameWidth(WFW), .FrameHeight(WFH), .PixelBitWidth(PW),
    .AddressWidthSDRAM(AW), .BurstLengthSDRAM(BL), .BaseAddr(WBASE)
  ) u_wrap (
    .CLK(clk), .RST(rst_n), .i_start(w_start), .o_busy(w_busy), .o_done(w_done),
    .o_sdram_enable(en1), .o_sdram_rw(rw1), .o_sdram_addr(addr1),
    .i_sdram_busy(w_sd_busy), .i_sdram_valid_rd(sd_valid[1]), .i_sdram_data(sd_data[1]),
    .o_pixel(w_pixel), .o_valid(w_valid), .i_ready(w_ready),
    .o_line_end(w_line_end), .o_frame_end(w_frame_end), .o_overrun(w_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Controller model: each request returns addr, addr+1, ... as data starting
  // three cycles after the request. Stimulus for ready/busy lives here too.
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      if (cyc >= pstart[d] && cyc < pstart[d] + BL) begin
        sd_valid[d] = 1'b1;
        sd_data[d]  = PW'(paddr[d] + cyc - pstart[d]);
      end else begin
        sd_valid[d] = 1'b0;
        sd_data[d]  = '0;
      end
    end
    if (cyc == inject_at) begin
      sd_valid[0] = 1'b1;
      sd_data[0]  = 16'hDEAD;
    end
    case (ready_mode)
      0:       ready = 1'b0;
      1:       ready = 1'b1;
      default: ready = ($urandom_range(0, 99) < 60);
    endcase
    sd_busy = busy_rand ? ($urandom_range(0, 3) == 0) : busy_force;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      pstart[0] = -100;
      pstart[1] = -100;
    end else begin
      if (en0) begin
        pstart[0] = cyc + 3;
        paddr[0]  = int'(addr0);
      end
      if (en1) begin
        pstart[1] = cyc + 3;
        paddr[1]  = int'(addr1);
      end
    end
  end

  // Scoreboard: pixel k of the frame must be BASE+k, requests at BASE+8j.
  always @(negedge clk) begin
    if (rst_n) begin
      if (en0) begin
        chk("req_rw", int'(rw0), 1);
        chk("req_while_busy", int'(sd_busy), 0);
        chk("req_addr", int'(addr0), (BASE + req_cnt * BL) % (1 << AW));
        chk("req_count_bound", int'(req_cnt < NB), 1);
        chk("req_prefetch_depth", int'(req_cnt - pix_out / BL <= 1), 1);
        req_log.push_back(int'(addr0));
        if (first_req_cyc < 0) first_req_cyc = cyc;
        req_cnt++;
      end
      if (prev_hold) begin
        chk("hold_valid", int'(valid), 1);
        chk("hold_pixel", int'(pixel), int'(prev_pix));
      end
      if (done) begin
        chk("done_after_last", int'(last_hs), 1);
        done_cnt++;
      end
      last_hs = 1'b0;
      if (valid && ready) begin
        chk("pixel", int'(pixel), (BASE + pix_out) % (1 << PW));
        chk("line_end", int'(line_end), int'(pix_out % FW == FW - 1));
        chk("frame_end", int'(frame_end), int'(pix_out == TOTAL - 1));
        if (pix_out == TOTAL - 1) begin
          last_hs  = 1'b1;
          last_pix = int'(pixel);
        end
        pix_out++;
      end
      prev_hold = valid && !ready;
      prev_pix  = pixel;

      if (en1) wreq.push_back(int'(addr1));
      if (w_valid && w_ready) wpix.push_back({w_frame_end, w_line_end, w_pixel});
      if (w_done) w_done_cnt++;
    end
  end

  task automatic begin_run();
    req_cnt = 0;
    pix_out = 0;
    done_cnt = 0;
    prev_hold = 1'b0;
    last_hs = 1'b0;
    first_req_cyc = -1;
    last_pix = 0;
    req_log.delete();
  endtask

  task automatic pulse_start(input logic both);
    @(posedge clk); #1;
    start = 1'b1;
    w_start = both;
    @(posedge clk); #1;
    start = 1'b0;
    w_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, int'(done_cnt != 0), 1);
    repeat (3) @(negedge clk);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_req_count"}, req_cnt, NB);
    chk({tag, "_pix_count"}, pix_out, TOTAL);
    chk({tag, "_busy_low"}, int'(busy), 0);
  endtask

  initial begin
    begin_run();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", int'({busy, done, en0, rw0, valid, line_end, frame_end, overrun}), 0);
    chk("rst_addr", int'(addr0), 0);
    chk("rst_pixel", int'(pixel), 0);
    rst_n = 1'b1;

    // Run 1: always ready, plus the wrapping-address instance.
    begin_run();
    ready_mode = 1;
    pulse_start(1'b1);
    wait_done("r1", 400);
    chk("r1_req0_lit", (req_log.size() > 0) ? req_log[0] : -1, 'h000100);
    chk("r1_req3_lit", (req_log.size() > 3) ? req_log[3] : -1, 'h000118);
    chk("r1_last_pixel_lit", last_pix, 'h011F);
    chk("r1_overrun", int'(overrun), 0);
    repeat (20) @(negedge clk);
    chk("wrap_req_count", wreq.size(), 2);
    chk("wrap_req0", (wreq.size() > 0) ? wreq[0] : -1, 'hFFFFF8);
    chk("wrap_req1", (wreq.size() > 1) ? wreq[1] : -1, 'h000000);
    chk("wrap_pix_count", wpix.size(), WTOTAL);
    for (int k = 0; k < wpix.size(); k++) begin
      logic [17:0] e;
      e = {1'(k == WTOTAL - 1), 1'(k % WFW == WFW - 1), PW'(WBASE + k)};
      chk("wrap_pixel", int'(wpix[k]), int'(e));
    end
    chk("wrap_done_count", w_done_cnt, 1);
    chk("wrap_busy_low", int'(w_busy), 0);

    // Run 2: downstream stalled, both buffers fill, then random ready.
    begin_run();
    ready_mode = 0;
    pulse_start(1'b0);
    repeat (60) @(negedge clk);
    chk("r2_req_stall", req_cnt, 2);
    chk("r2_valid_stall", int'(valid), 1);
    chk("r2_pixel_stall", int'(pixel), 'h0100);
    repeat (20) @(negedge clk);
    chk("r2_req_still", req_cnt, 2);
    chk("r2_pixel_still", int'(pixel), 'h0100);
    ready_mode = 2;
    wait_done("r2", 1500);

    // Run 3: controller busy at start, stray read word, ignored restart.
    begin_run();
    ready_mode = 1;
    @(negedge clk);
    busy_force = 1'b1;
    pulse_start(1'b0);
    repeat (5) @(negedge clk);
    inject_at = cyc + 1;
    repeat (14) @(negedge clk);
    chk("r3_no_req_while_busy", req_cnt, 0);
    busy_force = 1'b0;
    begin
      int fall_cyc;
      int n;
      fall_cyc = cyc + 1;
      n = 0;
      while (pix_out < 10 && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("r3_first_req_cycle", first_req_cyc, fall_cyc);
    end
    pulse_start(1'b0);
    wait_done("r3", 600);
    chk("r3_overrun", int'(overrun), 1);

    // Run 4: random ready and busy, reset mid-collect, then a clean frame.
    begin_run();
    ready_mode = 2;
    busy_rand = 1'b1;
    pulse_start(1'b0);
    @(negedge clk);
    chk("r4_overrun_cleared", int'(overrun), 0);
    begin
      int n = 0;
      while (req_cnt < 1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("r4_first_req_seen", int'(req_cnt >= 1), 1);
    end
    repeat (5) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("r4_async_rst_flags", int'({busy, done, en0, rw0, valid, line_end, frame_end, overrun}), 0);
    chk("r4_async_rst_addr", int'(addr0), 0);
    chk("r4_async_rst_pixel", int'(pixel), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    begin_run();
    pulse_start(1'b0);
    wait_done("r4", 3000);
    chk("r4_first_req_lit", (req_log.size() > 0) ? req_log[0] : -1, 'h000100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_frame_reader.md
Name: sdram_frame_reader

Overview:
- Reads one stored frame back out of SDRAM in 8-word bursts, addressed sequentially from a base address.
- Buffers each burst and streams the pixels to the Compressor/UART path through a valid/ready handshake.
- Is the read-side counterpart of the capture path (VGA -> FIFO -> SDRAM burst writes).
- Drives the SDRAM controller's request interface (enable/rw/addr) and consumes its read data and read-valid strobe.

Parameters:
- FrameWidth, 640, pixels per line.
- FrameHeight, 480, lines per frame.
- PixelBitWidth, 16, pixel/word width; equals the SDRAM word length.
- AddressWidthSDRAM, 24, SDRAM linear word address width (bank+row+col).
- BurstLengthSDRAM, 8, words per read burst; power of two; FrameWidth*FrameHeight must be a multiple of it.
- BaseAddr, 0, word address of the frame's first pixel.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- i_start  input  1  one-cycle pulse; begins a frame read when idle.
- o_busy  output  1  high from accepted i_start until o_done.
- o_done  output  1  one-cycle pulse after the last pixel handshake.
- o_sdram_enable  output  1  one-cycle burst request to the SDRAM controller.
- o_sdram_rw  output  1  1 = read; held 1 whenever o_sdram_enable is high.
- o_sdram_addr  output  AddressWidthSDRAM  burst start address.
- i_sdram_busy  input  1  controller cannot accept a request.
- i_sdram_valid_rd  input  1  i_sdram_data is a valid read word this cycle.
- i_sdram_data  input  PixelBitWidth  read word.
- o_pixel  output  PixelBitWidth  output pixel.
- o_valid  output  1  o_pixel valid.
- i_ready  input  1  downstream accepts o_pixel when o_valid && i_ready.
- o_line_end  output  1  qualifies o_pixel as the last pixel of a line.
- o_frame_end  output  1  qualifies o_pixel as the last pixel of the frame.
- o_overrun  output  1  sticky; set on an unexpected read word, cleared by i_start or reset.

Behaviour:
- Reset (RST low, asynchronous): every output is 0, FSM = IDLE, counters and buffer flags are cleared. A reset mid-frame abandons the frame with no o_done; the next i_start restarts from BaseAddr.
- Buffering: two BurstLengthSDRAM-word buffers (ping-pong). Fill side and drain side each keep a buffer index, and each buffer has a full flag.
- Request FSM states: IDLE, ISSUE, COLLECT, FINISH.
  - IDLE: when i_start=1, go to ISSUE. Clear the burst counter, pixel counters and o_overrun; o_busy<=1.
  - ISSUE: when !i_sdram_busy and the fill buffer is not full, hold o_sdram_enable=1 and o_sdram_rw=1 for exactly one cycle, with o_sdram_addr = BaseAddr + burst_idx*BurstLengthSDRAM (modulo 2^AddressWidthSDRAM), then go to COLLECT. Otherwise wait in ISSUE with enable low.
  - COLLECT: each i_sdram_valid_rd writes i_sdram_data into fill-buffer word word_idx and increments word_idx. On the BurstLengthSDRAM-th word: mark the buffer full, toggle the fill index, increment burst_idx. Then go to ISSUE if bursts remain, else FINISH.
  - FINISH: when the drain side has emitted the last pixel, pulse o_done for one cycle, set o_busy<=0, go to IDLE.
- Drain side: o_valid = drain buffer full. o_pixel = drain buffer[rd_idx], registered/stable while o_valid && !i_ready. On a handshake, rd_idx increments; after the last word, clear that buffer's full flag and toggle the drain index. The emptied buffer can be refilled in the next cycle.
- Markers: o_line_end=1 when col == FrameWidth-1. o_frame_end=1 when the pixel is the last of the frame. Both are valid only with o_valid.
- Latency: first o_sdram_enable 1 cycle after i_start (if not busy). First o_valid 1 cycle after the last word of burst 0 is captured.
- Prefetch: a second burst may be requested while the first is draining. No request is issued while both buffers are full.
- Boundaries and ignored/error events:
  - i_start while o_busy: ignored.
  - i_sdram_valid_rd outside COLLECT: word dropped, o_overrun<=1.
  - i_ready with o_valid=0: no effect.
  - Simultaneous buffer fill-complete and drain-complete on different buffers: both take effect in the same cycle.
- Counter widths: burst_idx uses $clog2(FrameWidth*FrameHeight/BurstLengthSDRAM) bits; col/row counters use $clog2(FrameWidth) and $clog2(FrameHeight) bits and wrap to 0 at frame end.

Test Plan:
- FrameWidth=16, FrameHeight=2, BaseAddr=0x100; model controller returns addr-as-data 3 cycles after each request, i_ready=1 -> exactly 4 requests at 0x100, 0x108, 0x110, 0x118; pixels 0x100..0x11F in order; o_line_end on pixels 15 and 31; o_frame_end on pixel 31; single o_done; o_busy low afterwards.
- Same setup, i_ready held 0 -> exactly 2 requests issued, then o_sdram_enable stays 0. o_pixel=0x100 stable with o_valid=1. Releasing i_ready resumes with no pixel lost or duplicated.
- i_sdram_busy forced high 20 cycles after i_start -> no request during busy; a request at 0x100 in the first cycle busy falls.
- BaseAddr=2^24-8, 2 bursts -> second request address is 0x000000 (wrap).
- Extra i_sdram_valid_rd pulse while in ISSUE -> o_overrun=1, pixel stream unchanged. A second i_start mid-frame -> ignored, request count unchanged.
- RST asserted mid-COLLECT -> all outputs 0 immediately (asynchronous). After release, i_start restarts at BaseAddr with correct data.
